sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock first-in/first-out buffer with parameterised depth and data width. Write and read requests are sampled on the same clock edge. Read data comes from a registered output, and full/empty status flags are provided. It sits between a producer and a consumer in the same clock domain and absorbs short bursts of up to FIFO_DEPTH words.

## Interface
- FIFO_DEPTH, default 8: number of storage entries; any integer ≥ 2.
- DATA_WIDTH, default 32: width of each stored word in bits.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-high reset (reset asserted when rst_n = 1, sampled on rising clk).
- wr_en  input  1  write request; pushes data_in on the rising edge when accepted.
- rd_en  input  1  read request; pops the oldest word into data_out on the rising edge when accepted.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when the FIFO holds 0 words.
- full  output  1  high when the FIFO holds FIFO_DEPTH words.

## Operation
- State:
  - storage array of FIFO_DEPTH × DATA_WIDTH;
  - write pointer and read pointer, each ceil(log2(FIFO_DEPTH)) bits;
  - occupancy count, ceil(log2(FIFO_DEPTH+1)) bits, range 0..FIFO_DEPTH.
- Write accepted when wr_en = 1 and full = 0:
  - mem[wr_ptr] ← data_in;
  - wr_ptr advances by one.
- Read accepted when rd_en = 1 and empty = 0:
  - data_out ← mem[rd_ptr];
  - rd_ptr advances by one.
- Pointer wrap: a pointer equal to FIFO_DEPTH-1 advances to 0. This holds for non-power-of-two depths too.
- Count update:
  - +1 for an accepted write only;
  - −1 for an accepted read only;
  - unchanged when both are accepted or neither is.
- Write when full is ignored: the word is dropped and no state changes. This applies even if rd_en is also high that cycle.
- Read when empty is ignored: data_out holds its previous value and no pointer moves. No fall-through: with empty = 1 and wr_en = rd_en = 1, only the write occurs.
- Simultaneous write and read with 0 < count < FIFO_DEPTH: both occur and the count is unchanged.
- Flags are combinational decodes of the count:
  - empty = (count == 0);
  - full = (count == FIFO_DEPTH).
- data_out changes only on an accepted read or on reset.
- Storage contents are not reset.

## Timing
- Reset, on the rising edge with rst_n = 1:
  - wr_ptr = rd_ptr = count = 0;
  - data_out = 0;
  - empty = 1, full = 0.
- Reset overrides wr_en and rd_en in the same cycle.
- Reset mid-operation discards all stored words.
- Write-to-flag latency: empty deasserts immediately after the edge that accepts the first write.
- Write-to-read: a word written at edge N can be read at edge N+1 at the earliest.
- Read latency:
  - rd_en is sampled high at edge N;
  - data_out is valid after edge N and stable through edge N+1.
- Full asserts after the edge that accepts the FIFO_DEPTH-th outstanding write. It deasserts after the edge that accepts a read.
- Back-to-back operation at one transfer per cycle is supported on each side.

## Test plan
- Reset, then write 1, 10, 100, each as a one-cycle wr_en pulse followed by an idle cycle. Then issue three one-cycle rd_en pulses. Required:
  - data_out = 1, then 10, then 100, in order;
  - empty = 0 after the first write;
  - empty = 1 after the third read.
- Interleave 8 times: write 2^i, then read, for i = 0..7. Required:
  - each read returns 2^i (1, 2, 4 … 128);
  - empty returns to 1 after every read;
  - full never asserts;
  - pointers wrap once through index 7→0.
- Overflow: write 2^i for i = 0..8 (9 writes) with no reads. Required:
  - full = 1 after the 8th write;
  - the 9th word (256) is dropped;
  - 8 reads return 1, 2, 4 … 128;
  - empty = 1 afterwards and full = 0 after the first read.
- Underflow: with the FIFO empty and data_out = 128, assert rd_en for 3 cycles. Required: data_out stays 128, empty stays 1, and the pointers do not move. A subsequent write then read returns the new word.
- Simultaneous access:
  - with 4 words held, assert wr_en and rd_en for 6 cycles; required: count stays 4, and reads return the oldest words in order;
  - with the FIFO full and both asserted, required: the read occurs, the write is dropped, and full deasserts.
- Mid-operation reset: write 5 words, assert rst_n = 1 for one cycle. Required: empty = 1, full = 0, data_out = 0. The next write/read pair returns only the new word.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and count-decoded full/empty flags.
// Depth need not be a power of two; pointers wrap explicitly at FIFO_DEPTH-1.
module sync_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  wr_accept;
    logic                  rd_accept;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    // A full FIFO drops the write even when a read frees a slot in the same cycle.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr   <= ptr_next(rd_ptr);
                data_out <= mem[rd_ptr];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (depth 8, width 32): ordering, flags, overflow,
// underflow, simultaneous access and mid-operation reset against hand-computed values.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;

    sync_fifo #(.FIFO_DEPTH(8), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic w, input logic r, input logic [31:0] d);
        @(negedge clk);
        rst_n   = rst;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_dout", data_out, 32'd0);

        // Basic ordering with idle cycles between operations.
        step(1'b0, 1'b1, 1'b0, 32'd1);
        check("first_write_empty", 32'(empty), 32'd0);
        idle();
        step(1'b0, 1'b1, 1'b0, 32'd10);
        idle();
        step(1'b0, 1'b1, 1'b0, 32'd100);
        idle();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("rd1", data_out, 32'd1);
        idle();
        check("rd1_hold", data_out, 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("rd2", data_out, 32'd10);
        idle();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("rd3", data_out, 32'd100);
        check("rd3_empty", 32'(empty), 32'd1);

        // Interleaved write/read; pointers cross the 7->0 wrap.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd1 << i);
            check("il_full", 32'(full), 32'd0);
            check("il_empty_w", 32'(empty), 32'd0);
            step(1'b0, 1'b0, 1'b1, 32'h0);
            check("il_data", data_out, 32'd1 << i);
            check("il_empty_r", 32'(empty), 32'd1);
        end

        // Overflow: ninth write is dropped.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd1 << i);
            if (i == 6) check("ovf_not_full_7", 32'(full), 32'd0);
            if (i >= 7) check("ovf_full", 32'(full), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            check("ovf_data", data_out, 32'd1 << i);
            if (i == 0) check("ovf_full_drop", 32'(full), 32'd0);
        end
        check("ovf_empty", 32'(empty), 32'd1);

        // Underflow: reads on an empty FIFO change nothing.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            check("unf_data", data_out, 32'd128);
            check("unf_empty", 32'(empty), 32'd1);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0000_abcd);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("unf_new_word", data_out, 32'h0000_abcd);
        check("unf_new_empty", 32'(empty), 32'd1);

        // Empty with both requests: only the write happens.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0042);
        check("nofall_dout", data_out, 32'h0000_abcd);
        check("nofall_empty", 32'(empty), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("nofall_read", data_out, 32'h0000_0042);

        // Simultaneous access with four words held.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 32'h11 * i);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'h55 + 32'h11 * i);
            check("sim_data", data_out, 32'h11 * (i + 1));
            check("sim_empty", 32'(empty), 32'd0);
            check("sim_full", 32'(full), 32'd0);
        end
        // Held now: 77 88 99 aa; fill to full.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'hbb + 32'h11 * i);
        check("sim_fill_full", 32'(full), 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'hff);
        check("full_both_data", data_out, 32'h77);
        check("full_both_full", 32'(full), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            check("full_both_drain", data_out, 32'h88 + 32'h11 * i);
        end
        check("full_both_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("full_both_dropped", data_out, 32'hee);

        // Mid-operation reset, with a write request that reset must override.
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 32'h100 + i);
        check("pre_rst_empty", 32'(empty), 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h999);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_dout", data_out, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h5a5a);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("post_rst_data", data_out, 32'h5a5a);
        check("post_rst_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("post_rst_no_old", data_out, 32'h5a5a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
